// File: rtl/seq_detect_pkg.sv
// Shared types, default widths and config checks for the serial pattern detector run controller.
package seq_detect_pkg;

  localparam int PAT_MAX = 8;
  localparam int CNT_W   = 8;
  localparam int TMO_W   = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  // A run needs a pattern length in 1..pat_max and a nonzero target count.
  function automatic logic cfg_legal(input logic [3:0] len, input logic target_nz,
                                     input int pat_max);
    return (len != 4'd0) && (int'(len) <= pat_max) && target_nz;
  endfunction

endpackage

// File: rtl/seq_detect_ctrl_if.sv
// Host/config and serial-stream signals of the pattern detector run controller.
interface seq_detect_ctrl_if
  import seq_detect_pkg::*;
#(
  parameter int PAT_MAX = seq_detect_pkg::PAT_MAX,
  parameter int CNT_W   = seq_detect_pkg::CNT_W,
  parameter int TMO_W   = seq_detect_pkg::TMO_W
);
  logic               start;
  logic               abort;
  logic [PAT_MAX-1:0] cfg_pattern;
  logic [3:0]         cfg_len;
  logic [CNT_W-1:0]   cfg_target;
  logic [TMO_W-1:0]   cfg_timeout;
  logic               data_in;
  logic               data_valid;
  logic               busy;
  logic               match_pulse;
  logic [CNT_W-1:0]   match_cnt;
  logic               done;
  logic               timeout;
  logic               err;

  modport master (
    output start, abort, cfg_pattern, cfg_len, cfg_target, cfg_timeout, data_in, data_valid,
    input  busy, match_pulse, match_cnt, done, timeout, err
  );

  modport slave (
    input  start, abort, cfg_pattern, cfg_len, cfg_target, cfg_timeout, data_in, data_valid,
    output busy, match_pulse, match_cnt, done, timeout, err
  );
endinterface

// File: rtl/seq_match_core.sv
// Bit-serial matcher: shift register, saturating history count and masked pattern compare.
module seq_match_core
  import seq_detect_pkg::*;
#(
  parameter int PAT_MAX = seq_detect_pkg::PAT_MAX,
  parameter bit REPEAT  = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               shift,
  input  logic               bit_in,
  input  logic [3:0]         len,
  input  logic [PAT_MAX-1:0] pattern,
  output logic               match
);

  logic [PAT_MAX-1:0] sr, sr_nxt, mask;
  logic [3:0]         hist, hist_nxt;

  always_comb begin
    mask = '0;
    for (int i = 0; i < PAT_MAX; i++) mask[i] = (i < int'(len));
    sr_nxt   = {sr[PAT_MAX-2:0], bit_in};
    hist_nxt = (hist >= len) ? hist : hist + 4'd1;
    match    = shift && (hist_nxt >= len) && (((sr_nxt ^ pattern) & mask) == '0);
  end

  // Non-overlapping mode restarts the history so the next match needs len fresh bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr   <= '0;
      hist <= '0;
    end else if (clr) begin
      sr   <= '0;
      hist <= '0;
    end else if (shift) begin
      sr   <= sr_nxt;
      hist <= (match && !REPEAT) ? 4'd0 : hist_nxt;
    end
  end

endmodule

// File: rtl/seq_detect_ctrl.sv
// Run controller for the serial pattern detector: FSM, match counter, timeout and status outputs.
// Build option SEQ_DETECT_CTRL_TIMEOUT_EN adds the RUN-cycle timeout counter.
//
// state | meaning
// IDLE  | waiting for start; config checked here
// ARM   | one cycle: clear matcher, match count and timeout counter
// RUN   | accept qualified bits, count matches
// DONE  | one cycle: done asserted
module seq_detect_ctrl
  import seq_detect_pkg::*;
#(
  parameter int PAT_MAX = seq_detect_pkg::PAT_MAX,
  parameter int CNT_W   = seq_detect_pkg::CNT_W,
  parameter int TMO_W   = seq_detect_pkg::TMO_W,
  parameter bit REPEAT  = 1'b1
) (
  input logic              clk,
  input logic              rst_n,
  seq_detect_ctrl_if.slave ifc
);

  state_t             state, state_nxt;
  logic [PAT_MAX-1:0] pat_q;
  logic [3:0]         len_q;
  logic [CNT_W-1:0]   tgt_q, cnt_q, cnt_inc;
  logic               pulse_q, err_q;
  logic               legal, accept_start, shift, match, hit_target, tmo_expire;

  assign legal        = cfg_legal(ifc.cfg_len, |ifc.cfg_target, PAT_MAX);
  assign accept_start = (state == IDLE) && ifc.start && legal;
  assign shift        = (state == RUN) && ifc.data_valid && !ifc.abort;
  assign cnt_inc      = cnt_q + 1'b1;
  assign hit_target   = match && (cnt_inc == tgt_q);

  seq_match_core #(.PAT_MAX(PAT_MAX), .REPEAT(REPEAT)) u_core (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (state == ARM),
    .shift   (shift),
    .bit_in  (ifc.data_in),
    .len     (len_q),
    .pattern (pat_q),
    .match   (match)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Abort outranks both target and timeout; target outranks timeout.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept_start) state_nxt = ARM;
      ARM:     state_nxt = ifc.abort ? IDLE : RUN;
      RUN:     if (ifc.abort) state_nxt = IDLE;
               else if (hit_target || tmo_expire) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pat_q   <= '0;
      len_q   <= '0;
      tgt_q   <= '0;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      pulse_q <= match;
      err_q   <= (state == IDLE) && ifc.start && !legal;
      if (accept_start) begin
        pat_q <= ifc.cfg_pattern;
        len_q <= ifc.cfg_len;
        tgt_q <= ifc.cfg_target;
      end
      if (state == ARM)  cnt_q <= '0;
      else if (match)    cnt_q <= cnt_inc;
    end
  end

`ifdef SEQ_DETECT_CTRL_TIMEOUT_EN
  logic [TMO_W-1:0] tmo_cfg_q, tmo_cnt, tmo_inc;
  logic             tmo_flag_q;

  assign tmo_inc    = tmo_cnt + 1'b1;
  assign tmo_expire = (state == RUN) && (tmo_cfg_q != '0) && (tmo_inc == tmo_cfg_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cfg_q  <= '0;
      tmo_cnt    <= '0;
      tmo_flag_q <= 1'b0;
    end else begin
      if (accept_start) begin
        tmo_cfg_q  <= ifc.cfg_timeout;
        tmo_flag_q <= 1'b0;
      end else if ((state == RUN) && !ifc.abort && !hit_target && tmo_expire) begin
        tmo_flag_q <= 1'b1;
      end
      if (state == ARM)      tmo_cnt <= '0;
      else if (state == RUN) tmo_cnt <= tmo_inc;
    end
  end

  assign ifc.timeout = tmo_flag_q;
`else
  logic unused_cfg_timeout;

  assign unused_cfg_timeout = ^ifc.cfg_timeout;
  assign tmo_expire         = 1'b0;
  assign ifc.timeout        = 1'b0;
`endif

  assign ifc.busy        = (state != IDLE);
  assign ifc.done        = (state == DONE);
  assign ifc.match_pulse = pulse_q;
  assign ifc.match_cnt   = cnt_q;
  assign ifc.err         = err_q;

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Directed bench for seq_detect_ctrl: overlapping (dut0) and non-overlapping (dut1) instances share stimulus.
module tb_seq_detect_ctrl;

  typedef struct {
    int cyc;
    int cnt;
    int tmo;
  } ev_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   n_vec;
  int   n_err;
  int   t;
  logic [7:0] s;
  ev_t  pq0[$], pq1[$], dq0[$], dq1[$];
  ev_t  e;

  seq_detect_ctrl_if ifc0 ();
  seq_detect_ctrl_if ifc1 ();

  assign ifc1.start       = ifc0.start;
  assign ifc1.abort       = ifc0.abort;
  assign ifc1.cfg_pattern = ifc0.cfg_pattern;
  assign ifc1.cfg_len     = ifc0.cfg_len;
  assign ifc1.cfg_target  = ifc0.cfg_target;
  assign ifc1.cfg_timeout = ifc0.cfg_timeout;
  assign ifc1.data_in     = ifc0.data_in;
  assign ifc1.data_valid  = ifc0.data_valid;

  seq_detect_ctrl #(.REPEAT(1'b1)) dut0 (.clk(clk), .rst_n(rst_n), .ifc(ifc0));
  seq_detect_ctrl #(.REPEAT(1'b0)) dut1 (.clk(clk), .rst_n(rst_n), .ifc(ifc1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic cfg_start(input logic [7:0] pat, input logic [3:0] len,
                           input logic [7:0] tgt, input logic [15:0] tmo);
    ifc0.cfg_pattern = pat;
    ifc0.cfg_len     = len;
    ifc0.cfg_target  = tgt;
    ifc0.cfg_timeout = tmo;
    ifc0.start       = 1'b1;
    t = cyc;
    tick();
    ifc0.start = 1'b0;
  endtask

  // Scoreboard: pulses and done cycles are compared against queued expectations.
  always @(negedge clk) begin
    if (ifc0.match_pulse) begin
      if (pq0.size() == 0) chk("pulse0_unexpected", ifc0.match_pulse, 0);
      else begin
        e = pq0.pop_front();
        chk("pulse0_cycle", cyc, e.cyc);
        chk("pulse0_cnt", ifc0.match_cnt, e.cnt);
      end
    end else if (pq0.size() != 0 && pq0[0].cyc <= cyc) begin
      e = pq0.pop_front();
      chk("pulse0_missing", ifc0.match_pulse, 1);
    end
    if (ifc0.done) begin
      if (dq0.size() == 0) chk("done0_unexpected", ifc0.done, 0);
      else begin
        e = dq0.pop_front();
        chk("done0_cycle", cyc, e.cyc);
        chk("done0_cnt", ifc0.match_cnt, e.cnt);
        chk("done0_timeout", ifc0.timeout, e.tmo);
      end
    end else if (dq0.size() != 0 && dq0[0].cyc <= cyc) begin
      e = dq0.pop_front();
      chk("done0_missing", ifc0.done, 1);
    end
    if (ifc1.match_pulse) begin
      if (pq1.size() == 0) chk("pulse1_unexpected", ifc1.match_pulse, 0);
      else begin
        e = pq1.pop_front();
        chk("pulse1_cycle", cyc, e.cyc);
        chk("pulse1_cnt", ifc1.match_cnt, e.cnt);
      end
    end else if (pq1.size() != 0 && pq1[0].cyc <= cyc) begin
      e = pq1.pop_front();
      chk("pulse1_missing", ifc1.match_pulse, 1);
    end
    if (ifc1.done) begin
      if (dq1.size() == 0) chk("done1_unexpected", ifc1.done, 0);
      else begin
        e = dq1.pop_front();
        chk("done1_cycle", cyc, e.cyc);
        chk("done1_cnt", ifc1.match_cnt, e.cnt);
        chk("done1_timeout", ifc1.timeout, e.tmo);
      end
    end else if (dq1.size() != 0 && dq1[0].cyc <= cyc) begin
      e = dq1.pop_front();
      chk("done1_missing", ifc1.done, 1);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: run still active at %0t, required to finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    ifc0.start = 1'b0;       ifc0.abort = 1'b0;
    ifc0.cfg_pattern = '0;   ifc0.cfg_len = '0;
    ifc0.cfg_target = '0;    ifc0.cfg_timeout = '0;
    ifc0.data_in = 1'b0;     ifc0.data_valid = 1'b0;
    tick(2);
    chk("rst_busy", ifc0.busy, 0);
    chk("rst_outs0", {ifc0.match_pulse, ifc0.match_cnt, ifc0.done, ifc0.timeout, ifc0.err}, 0);
    rst_n = 1'b1;
    tick(2);

    // 10010 over 1,0,0,1,0,0,1,0: overlap matches at bits 5 and 8, non-overlap only at bit 5
    cfg_start(8'h12, 4'd5, 8'd2, 16'd0);
    chk("arm_busy0", ifc0.busy, 1);
    tick();
    s = 8'b1001_0010;
    for (int i = 0; i < 8; i++) begin
      ifc0.data_in    = s[7-i];
      ifc0.data_valid = 1'b1;
      if (i == 4) begin
        pq0.push_back('{cyc + 1, 1, 0});
        pq1.push_back('{cyc + 1, 1, 0});
      end
      if (i == 7) begin
        pq0.push_back('{cyc + 1, 2, 0});
        dq0.push_back('{cyc + 1, 2, 0});
      end
      tick();
    end
    ifc0.data_valid = 1'b0;
    tick();
    chk("t1_idle_busy0", ifc0.busy, 0);
    chk("t1_cnt_hold0", ifc0.match_cnt, 2);
    chk("t1_run_busy1", ifc1.busy, 1);
    chk("t1_cnt1", ifc1.match_cnt, 1);
    ifc0.abort = 1'b1;
    tick();
    ifc0.abort = 1'b0;
    chk("abort_busy1", ifc1.busy, 0);
    chk("abort_cnt1", ifc1.match_cnt, 1);
    chk("abort_done1", ifc1.done, 0);
    tick();

    // illegal configurations
    ifc0.cfg_len = 4'd0; ifc0.cfg_target = 8'd2; ifc0.start = 1'b1;
    tick();
    ifc0.start = 1'b0;
    chk("err_len0", ifc0.err, 1);
    chk("err_len0_dut1", ifc1.err, 1);
    chk("err_len0_busy", ifc0.busy, 0);
    chk("err_len0_cnt", ifc0.match_cnt, 2);
    tick();
    chk("err_single", ifc0.err, 0);
    ifc0.cfg_len = 4'd5; ifc0.cfg_target = 8'd0; ifc0.start = 1'b1;
    tick();
    ifc0.start = 1'b0;
    chk("err_tgt0", ifc0.err, 1);
    chk("err_tgt0_busy", ifc0.busy, 0);
    chk("err_tgt0_cnt1", ifc1.match_cnt, 1);
    tick();
    chk("err_single2", ifc0.err, 0);
    ifc0.cfg_len = 4'd9; ifc0.cfg_target = 8'd2; ifc0.start = 1'b1;
    tick();
    ifc0.start = 1'b0;
    chk("err_len9", ifc0.err, 1);
    chk("err_len9_busy", ifc0.busy, 0);
    tick();

    // timeout window of 10 RUN cycles on an all-zero stream
    cfg_start(8'h12, 4'd5, 8'd2, 16'd10);
    ifc0.data_in    = 1'b0;
    ifc0.data_valid = 1'b1;
`ifdef SEQ_DETECT_CTRL_TIMEOUT_EN
    dq0.push_back('{t + 12, 0, 1});
    dq1.push_back('{t + 12, 0, 1});
`endif
    tick(10);
    chk("tmo_busy_pre", ifc0.busy, 1);
    chk("tmo_flag_pre", ifc0.timeout, 0);
    tick(2);
`ifdef SEQ_DETECT_CTRL_TIMEOUT_EN
    chk("tmo_idle", ifc0.busy, 0);
    chk("tmo_sticky", ifc0.timeout, 1);
    chk("tmo_cnt", ifc0.match_cnt, 0);
`else
    chk("notmo_busy", ifc0.busy, 1);
    chk("notmo_flag", ifc0.timeout, 0);
`endif
    ifc0.data_valid = 1'b0;
    ifc0.abort = 1'b1;
    tick();
    ifc0.abort = 1'b0;
    chk("post_tmo_busy", ifc0.busy, 0);

    // target reached on the same cycle the 5-cycle window expires
    cfg_start(8'h01, 4'd1, 8'd3, 16'd5);
    chk("start_clears_tmo", ifc0.timeout, 0);
    tick();
    for (int i = 0; i < 5; i++) begin
      ifc0.data_in    = 1'b1;
      ifc0.data_valid = (i % 2 == 0) ? 1'b1 : 1'b0;
      if (i % 2 == 0) begin
        pq0.push_back('{cyc + 1, i / 2 + 1, 0});
        pq1.push_back('{cyc + 1, i / 2 + 1, 0});
      end
      if (i == 4) begin
        dq0.push_back('{cyc + 1, 3, 0});
        dq1.push_back('{cyc + 1, 3, 0});
      end
      tick();
    end
    ifc0.data_valid = 1'b0;
    tick();
    chk("tie_busy", ifc0.busy, 0);
    chk("tie_tmo", ifc0.timeout, 0);
    chk("tie_cnt", ifc0.match_cnt, 3);

    // asynchronous reset in the middle of a run
    cfg_start(8'h12, 4'd5, 8'd2, 16'd0);
    tick();
    s = 8'b1001_0000;
    for (int i = 0; i < 5; i++) begin
      ifc0.data_in    = s[7-i];
      ifc0.data_valid = 1'b1;
      if (i == 4) begin
        pq0.push_back('{cyc + 1, 1, 0});
        pq1.push_back('{cyc + 1, 1, 0});
      end
      tick();
    end
    ifc0.data_valid = 1'b0;
    chk("pre_rst_cnt", ifc0.match_cnt, 1);
    chk("pre_rst_busy", ifc0.busy, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_outs0", {ifc0.busy, ifc0.match_pulse, ifc0.match_cnt, ifc0.done, ifc0.timeout, ifc0.err}, 0);
    chk("rst_mid_outs1", {ifc1.busy, ifc1.match_pulse, ifc1.match_cnt, ifc1.done, ifc1.timeout, ifc1.err}, 0);
    tick();
    rst_n = 1'b1;
    tick();
    cfg_start(8'h01, 4'd1, 8'd1, 16'd0);
    tick();
    ifc0.data_in    = 1'b1;
    ifc0.data_valid = 1'b1;
    pq0.push_back('{cyc + 1, 1, 0});
    pq1.push_back('{cyc + 1, 1, 0});
    dq0.push_back('{cyc + 1, 1, 0});
    dq1.push_back('{cyc + 1, 1, 0});
    tick();
    ifc0.data_valid = 1'b0;
    tick();
    chk("post_rst_busy", ifc0.busy, 0);
    chk("post_rst_cnt", ifc0.match_cnt, 1);
    tick(2);
    chk("sb_empty", pq0.size() + pq1.size() + dq0.size() + dq1.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
